// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encoding and default NOP word for the instruction load memory
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } imem_state_e;

    localparam logic [15:0] IMEM_NOP_DEFAULT = 16'hF000;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - single write port, single synchronous read port instruction storage
module imem_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write on request; read data register only moves on a read so it holds between fetches
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_load_mem.sv
// rtl/instr_load_mem.sv - program load FSM with range-checked single-cycle instruction fetch
module instr_load_mem
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       load_last,
    output logic                       load_ready,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic [DATA_W-1:0]          instruction,
    output logic                       fetch_valid,
    output logic                       addr_err,
    output logic                       ready,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

    imem_state_e       state_q;
    logic [CNT_W-1:0]  word_count_q;
    logic              overflow_q;
    logic              fetch_valid_q;
    logic              addr_err_q;
    logic              nop_sel_q;

    logic              room;
    logic              in_range;
    logic              accept;
    logic              fetch_hit;
    logic [DATA_W-1:0] ram_rdata;

    // Both operands widened to a common width so large addresses never wrap into range
    assign room      = word_count_q < CNT_W'(DEPTH);
    assign in_range  = CMP_W'(fetch_addr) < CMP_W'(word_count_q);
    assign accept    = !rst && !load_start && (state_q == ST_LOAD) && load_valid && room;
    assign fetch_hit = !rst && !load_start && (state_q == ST_RUN) && fetch_req && in_range;

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (accept),
        .waddr_i (word_count_q[AW-1:0]),
        .wdata_i (load_data),
        .re_i    (fetch_hit),
        .raddr_i (fetch_addr[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Load/run sequencing plus fetch response flags; load_start outranks any same-cycle load or fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            word_count_q  <= '0;
            overflow_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            nop_sel_q     <= 1'b1;
        end else begin
            fetch_valid_q <= fetch_req;
            addr_err_q    <= fetch_req && !load_start && (state_q == ST_RUN) && !in_range;
            if (fetch_req) begin
                nop_sel_q <= !fetch_hit;
            end

            if (load_start) begin
                state_q      <= ST_LOAD;
                word_count_q <= '0;
                overflow_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (load_valid) begin
                            if (room) begin
                                word_count_q <= word_count_q + 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                            if (load_last) begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load_ready  = (state_q == ST_LOAD) && room;
    assign ready       = (state_q == ST_RUN);
    assign word_count  = word_count_q;
    assign overflow    = overflow_q;
    assign fetch_valid = fetch_valid_q;
    assign addr_err    = addr_err_q;
    assign instruction = nop_sel_q ? NOP_WORD : ram_rdata;

endmodule

// File: tb/tb_instr_load_mem.sv
// tb/tb_instr_load_mem.sv - self-checking bench for instr_load_mem
`timescale 1ns/1ps
module tb_instr_load_mem;

    localparam int DEPTH = 32;
    localparam logic [15:0] NOP = 16'hF000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic [15:0] instruction;
    logic        fetch_valid;
    logic        addr_err;
    logic        ready;
    logic [5:0]  word_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: 0 = idle, 1 = loading, 2 = running
    int          m_mode = 0;
    int          m_cnt  = 0;
    bit          m_ovf  = 1'b0;
    logic [15:0] m_mem [DEPTH];
    logic [15:0] e_instr = NOP;
    bit          e_fv = 1'b0;
    bit          e_ae = 1'b0;

    instr_load_mem dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .instruction (instruction),
        .fetch_valid (fetch_valid),
        .addr_err    (addr_err),
        .ready       (ready),
        .word_count  (word_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs presented at this rising edge
    always @(posedge clk) begin
        int a;
        a = int'(fetch_addr);
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_ovf = 1'b0;
            e_instr = NOP; e_fv = 1'b0; e_ae = 1'b0;
        end else begin
            e_fv = fetch_req;
            e_ae = 1'b0;
            if (fetch_req) begin
                if (m_mode == 2 && !load_start && a < m_cnt) begin
                    e_instr = m_mem[a];
                end else begin
                    e_instr = NOP;
                    e_ae = (m_mode == 2) && !load_start;
                end
            end
            if (load_start) begin
                m_mode = 1; m_cnt = 0; m_ovf = 1'b0;
            end else if (m_mode == 1 && load_valid) begin
                if (m_cnt < DEPTH) begin
                    m_mem[m_cnt] = load_data;
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
                if (load_last) m_mode = 2;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("instruction", instruction, e_instr);
            check("fetch_valid", fetch_valid, e_fv);
            check("addr_err", addr_err, e_ae);
            check("ready", ready, m_mode == 2);
            check("load_ready", load_ready, (m_mode == 1) && (m_cnt < DEPTH));
            check("word_count", word_count, m_cnt);
            check("overflow", overflow, m_ovf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] addr);
        fetch_req = 1'b1; fetch_addr = addr;
        cyc();
        fetch_req = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input bit last);
        load_valid = 1'b1; load_data = d; load_last = last;
        cyc();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_instr", instruction, 16'hF000);
        check("rst_word_count", word_count, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_ready", ready, 0);
        rst = 1'b0;
        cyc();

        // Fetch before any load
        fetch(16'h0000);
        check("idle_instr", instruction, 16'hF000);
        check("idle_fv", fetch_valid, 1);
        check("idle_ae", addr_err, 0);
        check("idle_ready", ready, 0);
        cyc();
        check("fv_pulse", fetch_valid, 0);

        // Two-word program
        start_load();
        check("load_ready_in_load", load_ready, 1);
        push(16'h1234, 1'b0);
        cyc();
        push(16'h5678, 1'b1);
        check("run_ready", ready, 1);
        check("run_count", word_count, 2);
        fetch(16'h0001);
        check("fetch1", instruction, 16'h5678);
        check("fetch1_ae", addr_err, 0);
        fetch(16'h0000);
        check("fetch0", instruction, 16'h1234);
        fetch(16'h0002);
        check("fetch2", instruction, 16'hF000);
        check("fetch2_ae", addr_err, 1);
        fetch(16'hFFFF);
        check("fetchFFFF", instruction, 16'hF000);
        check("fetchFFFF_ae", addr_err, 1);
        cyc();
        check("ae_pulse", addr_err, 0);
        check("instr_hold", instruction, 16'hF000);

        // Overflow: 33 words into 32 locations
        start_load();
        for (int i = 0; i <= DEPTH; i++) begin
            if (i == DEPTH) begin
                check("full_load_ready", load_ready, 0);
                check("full_count", word_count, 32);
            end
            push(16'hA000 + 16'(i), i == DEPTH);
        end
        check("ovf_flag", overflow, 1);
        check("ovf_ready", ready, 1);
        fetch(16'd31);
        check("fetch31", instruction, 16'hA01F);
        fetch(16'd32);
        check("fetch32_ae", addr_err, 1);

        // load_start beats a same-cycle fetch
        load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0000;
        cyc();
        load_start = 1'b0; fetch_req = 1'b0;
        check("ls_fetch_instr", instruction, 16'hF000);
        check("ls_fetch_ae", addr_err, 0);
        check("ls_ready", ready, 0);
        check("ls_count", word_count, 0);
        check("ls_ovf", overflow, 0);
        push(16'hBEEF, 1'b1);
        fetch(16'h0001);
        check("stale_hidden", addr_err, 1);
        fetch(16'h0000);
        check("reload0", instruction, 16'hBEEF);

        // Restart mid-load, then reset mid-load
        start_load();
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        load_start = 1'b1; load_valid = 1'b1; load_data = 16'h3333;
        cyc();
        load_start = 1'b0; load_valid = 1'b0;
        check("restart_count", word_count, 0);
        push(16'h4444, 1'b0);
        push(16'h5555, 1'b0);
        push(16'h6666, 1'b0);
        rst = 1'b1; load_valid = 1'b1; load_data = 16'h7777;
        cyc();
        rst = 1'b0;
        check("mid_rst_count", word_count, 0);
        check("mid_rst_load_ready", load_ready, 0);
        check("mid_rst_instr", instruction, 16'hF000);
        cyc();
        load_valid = 1'b0;
        check("idle_ignores_load", word_count, 0);
        fetch(16'h0000);
        check("post_rst_fetch", instruction, 16'hF000);
        check("post_rst_ae", addr_err, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_load_mem.md
INSTR_LOAD_MEM -- requirements
Module: instr_load_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, fetch address width in bits.
REQ-003 SHALL have parameter DEPTH, default 32, number of instruction words stored; legal range 2..2**ADDR_W.
REQ-004 SHALL have parameter NOP_WORD, default 16'hF000, word returned whenever no valid instruction exists.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-007 SHALL have port load_start, input, 1 bit, one-cycle pulse that begins a program load.
REQ-008 SHALL have port load_valid, input, 1 bit, load_data carries a word.
REQ-009 SHALL have port load_data, input, DATA_W bits, program word.
REQ-010 SHALL have port load_last, input, 1 bit, qualifies the final word of a load.
REQ-011 SHALL have port load_ready, output, 1 bit, high when a load word can be accepted.
REQ-012 SHALL have port fetch_req, input, 1 bit, fetch request.
REQ-013 SHALL have port fetch_addr, input, ADDR_W bits, word address to fetch.
REQ-014 SHALL have port instruction, output, DATA_W bits, fetched word, registered.
REQ-015 SHALL have port fetch_valid, output, 1 bit, instruction is the response to the previous cycle's request.
REQ-016 SHALL have port addr_err, output, 1 bit, previous request was out of range.
REQ-017 SHALL have port ready, output, 1 bit, program loaded; processor may execute.
REQ-018 SHALL have port word_count, output, $clog2(DEPTH+1) bits, number of words loaded.
REQ-019 SHALL have port overflow, output, 1 bit, sticky: words offered beyond DEPTH were dropped.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-021 IDLE SHALL go to LOAD on load_start; no other exit.
REQ-022 LOAD SHALL write each accepted word (load_valid & load_ready) to location word_count, then increment word_count.
REQ-023 LOAD SHALL go to RUN in the cycle after the accepted word carrying load_last; ready SHALL be 1 in RUN only.
REQ-024 load_ready SHALL be 1 in LOAD while word_count < DEPTH, and 0 otherwise.
REQ-025 load_valid in LOAD with word_count == DEPTH SHALL drop the word and set overflow; load_last on a dropped word SHALL still go to RUN.
REQ-026 load_start in LOAD or RUN SHALL clear word_count and overflow and enter LOAD; it SHALL take priority over a same-cycle load or fetch.
REQ-027 Memory contents SHALL NOT be cleared by load_start; only locations below word_count SHALL be readable.
REQ-028 Fetch latency SHALL be exactly 1 cycle: fetch_req at edge N gives instruction, fetch_valid, and addr_err valid after edge N+1, held until the next request.
REQ-029 A fetch in RUN with fetch_addr < word_count SHALL return the stored word, with addr_err 0.
REQ-030 A fetch in RUN with fetch_addr >= word_count SHALL return NOP_WORD, with addr_err 1.
REQ-031 A fetch outside RUN SHALL return NOP_WORD, with fetch_valid 1 and addr_err 0.
REQ-032 fetch_valid and addr_err SHALL be single-cycle pulses; with no request, instruction holds its last value.
REQ-033 The address comparison SHALL be full ADDR_W unsigned, with no truncation or wrap.

Reset
REQ-034 rst SHALL set state IDLE, instruction=NOP_WORD, fetch_valid=0, addr_err=0, ready=0, load_ready=0, word_count=0, and overflow=0.
REQ-035 rst SHALL override all other inputs in the same cycle, including mid-load; memory array contents are undefined after reset.

Structure
REQ-036 State encoding and the NOP_WORD default SHALL reside in shared package imem_pkg.
REQ-037 The storage array SHALL be sub-module imem_ram (1 write port, 1 synchronous read port), parametrised by DATA_W and DEPTH.

Verification
REQ-038 Reset, then fetch addr 0 -> instruction=16'hF000, fetch_valid=1, addr_err=0, ready=0.
REQ-039 Load 16'h1234, 16'h5678 (last) and fetch addr 1 -> 16'h5678 one cycle later, with ready=1 and word_count=2.
REQ-040 Fetch addr 2 after a 2-word load -> 16'hF000 with addr_err=1; fetch addr 16'hFFFF -> same response.
REQ-041 Offer 33 words with DEPTH=32 -> 33rd word dropped, overflow=1, load_ready=0 at count 32, RUN entered on last.
REQ-042 Assert load_start with a same-cycle fetch in RUN -> fetch returns 16'hF000, ready=0, word_count=0.
REQ-043 Assert rst during LOAD after 3 words -> next cycle IDLE, word_count=0, load_ready=0, instruction=16'hF000.
